// File: rtl/bp_cacc_csr_endpoint.sv
// rtl/bp_cacc_csr_endpoint.sv - CSR endpoint for a coherent accelerator tile on the CCE I/O channel
// Decodes uncached I/O commands into CSR accesses and drives the datapath start/done handshake.
module bp_cacc_csr_endpoint #(
  parameter int addr_width_p    = 40,
  parameter int data_width_p    = 64,
  parameter int payload_width_p = 16,
  parameter int len_width_p     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       io_cmd_v_i,
  output logic                       io_cmd_ready_and_o,
  input  logic [3:0]                 io_cmd_type_i,
  input  logic [addr_width_p-1:0]    io_cmd_addr_i,
  input  logic [2:0]                 io_cmd_size_i,
  input  logic [payload_width_p-1:0] io_cmd_payload_i,
  input  logic [data_width_p-1:0]    io_cmd_data_i,

  output logic                       io_resp_v_o,
  input  logic                       io_resp_yumi_i,
  output logic [3:0]                 io_resp_type_o,
  output logic [addr_width_p-1:0]    io_resp_addr_o,
  output logic [2:0]                 io_resp_size_o,
  output logic [payload_width_p-1:0] io_resp_payload_o,
  output logic [data_width_p-1:0]    io_resp_data_o,

  output logic                       start_o,
  output logic                       busy_o,
  output logic [addr_width_p-1:0]    a_ptr_o,
  output logic [addr_width_p-1:0]    b_ptr_o,
  output logic [len_width_p-1:0]     len_o,
  input  logic                       done_i,
  input  logic [data_width_p-1:0]    result_i
);

  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'b0010;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'b0011;

  localparam logic [4:0] csr_a_ptr  = 5'd0;
  localparam logic [4:0] csr_b_ptr  = 5'd1;
  localparam logic [4:0] csr_len    = 5'd2;
  localparam logic [4:0] csr_start  = 5'd3;
  localparam logic [4:0] csr_status = 5'd4;
  localparam logic [4:0] csr_result = 5'd5;

  typedef enum logic {e_ready, e_resp} cmd_state_e;
  typedef enum logic {e_idle, e_busy} acc_state_e;

  cmd_state_e cmd_state;
  acc_state_e acc_state;

  logic [addr_width_p-1:0] a_ptr;
  logic [addr_width_p-1:0] b_ptr;
  logic [len_width_p-1:0]  len;
  logic [data_width_p-1:0] result;
  logic                    done;
  logic                    overrun;
  logic                    busy;
  logic                    start;
  logic                    cmd_ready;
  logic                    resp_v;

  logic [4:0]              sel;
  logic                    accept;
  logic                    is_wr;
  logic                    is_uc_rd;
  logic                    start_wr;
  logic                    status_clr;
  logic [data_width_p-1:0] rdata;

  // Only the low CSR-width bits of write data reach any register.
  logic unused_data_bits;
  assign unused_data_bits = ^io_cmd_data_i;

  assign sel        = io_cmd_addr_i[7:3];
  assign accept     = io_cmd_v_i & cmd_ready;
  assign is_wr      = (io_cmd_type_i == e_bedrock_mem_uc_wr);
  assign is_uc_rd   = (io_cmd_type_i == e_bedrock_mem_uc_rd);
  assign start_wr   = accept & is_wr & (sel == csr_start);
  assign status_clr = accept & is_uc_rd & (sel == csr_status);

  always_comb begin
    rdata = '0;
    case (sel)
      csr_a_ptr:  rdata[addr_width_p-1:0] = a_ptr;
      csr_b_ptr:  rdata[addr_width_p-1:0] = b_ptr;
      csr_len:    rdata[len_width_p-1:0]  = len;
      csr_status: rdata[2:0]              = {overrun, done, busy};
      csr_result: rdata                   = result;
      default:    rdata                   = '0;
    endcase
  end

  // Ready is held low for one cycle after reset so it rises on the first edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_state         <= e_ready;
      cmd_ready         <= 1'b0;
      resp_v            <= 1'b0;
      io_resp_type_o    <= '0;
      io_resp_addr_o    <= '0;
      io_resp_size_o    <= '0;
      io_resp_payload_o <= '0;
      io_resp_data_o    <= '0;
    end else begin
      case (cmd_state)
        e_ready: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            io_resp_type_o    <= io_cmd_type_i;
            io_resp_addr_o    <= io_cmd_addr_i;
            io_resp_size_o    <= io_cmd_size_i;
            io_resp_payload_o <= io_cmd_payload_i;
            io_resp_data_o    <= is_wr ? '0 : rdata;
            resp_v            <= 1'b1;
            cmd_ready         <= 1'b0;
            cmd_state         <= e_resp;
          end
        end
        e_resp: begin
          if (io_resp_yumi_i) begin
            resp_v    <= 1'b0;
            cmd_ready <= 1'b1;
            cmd_state <= e_ready;
          end
        end
        default: cmd_state <= e_ready;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_ptr <= '0;
      b_ptr <= '0;
      len   <= '0;
    end else if (accept && is_wr) begin
      case (sel)
        csr_a_ptr: a_ptr <= io_cmd_data_i[addr_width_p-1:0];
        csr_b_ptr: b_ptr <= io_cmd_data_i[addr_width_p-1:0];
        csr_len:   len   <= io_cmd_data_i[len_width_p-1:0];
        default:   ;
      endcase
    end
  end

  // The START decision uses the pre-edge state, so a START coincident with done
  // still counts as an overrun; a same-cycle done sets the flag after any clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_state <= e_idle;
      busy      <= 1'b0;
      start     <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      result    <= '0;
    end else begin
      start <= 1'b0;
      if (status_clr) begin
        done    <= 1'b0;
        overrun <= 1'b0;
      end
      case (acc_state)
        e_idle: begin
          if (start_wr) begin
            start     <= 1'b1;
            busy      <= 1'b1;
            acc_state <= e_busy;
          end
        end
        e_busy: begin
          if (done_i) begin
            result    <= result_i;
            done      <= 1'b1;
            busy      <= 1'b0;
            acc_state <= e_idle;
          end
          if (start_wr) overrun <= 1'b1;
        end
        default: acc_state <= e_idle;
      endcase
    end
  end

  assign io_cmd_ready_and_o = cmd_ready;
  assign io_resp_v_o        = resp_v;
  assign start_o            = start;
  assign busy_o             = busy;
  assign a_ptr_o            = a_ptr;
  assign b_ptr_o            = b_ptr;
  assign len_o              = len;

endmodule

// File: tb/tb_bp_cacc_csr_endpoint.sv
// tb/tb_bp_cacc_csr_endpoint.sv - directed self-checking bench for bp_cacc_csr_endpoint
module tb_bp_cacc_csr_endpoint;

  localparam logic [3:0] uc_rd = 4'b0010;
  localparam logic [3:0] uc_wr = 4'b0011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_v;
  logic        cmd_ready;
  logic [3:0]  cmd_type;
  logic [39:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [15:0] cmd_payload;
  logic [63:0] cmd_data;
  logic        resp_v;
  logic        resp_yumi;
  logic [3:0]  resp_type;
  logic [39:0] resp_addr;
  logic [2:0]  resp_size;
  logic [15:0] resp_payload;
  logic [63:0] resp_data;
  logic        start;
  logic        busy;
  logic [39:0] a_ptr;
  logic [39:0] b_ptr;
  logic [15:0] len;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic        rsp_start;
  logic        rsp_busy;
  logic [63:0] rd;

  always #5 clk = ~clk;

  bp_cacc_csr_endpoint dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .io_cmd_v_i         (cmd_v),
    .io_cmd_ready_and_o (cmd_ready),
    .io_cmd_type_i      (cmd_type),
    .io_cmd_addr_i      (cmd_addr),
    .io_cmd_size_i      (cmd_size),
    .io_cmd_payload_i   (cmd_payload),
    .io_cmd_data_i      (cmd_data),
    .io_resp_v_o        (resp_v),
    .io_resp_yumi_i     (resp_yumi),
    .io_resp_type_o     (resp_type),
    .io_resp_addr_o     (resp_addr),
    .io_resp_size_o     (resp_size),
    .io_resp_payload_o  (resp_payload),
    .io_resp_data_o     (resp_data),
    .start_o            (start),
    .busy_o             (busy),
    .a_ptr_o            (a_ptr),
    .b_ptr_o            (b_ptr),
    .len_o              (len),
    .done_i             (done),
    .result_i           (result)
  );

  always @(negedge clk) if (start) start_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response is consumed.
  task automatic cmd(input logic [3:0] t, input logic [39:0] a, input logic [63:0] d,
                     input logic [15:0] p, output logic [63:0] data);
    int n = 0;
    cmd_v = 1'b1; cmd_type = t; cmd_addr = a; cmd_size = 3'd3; cmd_payload = p; cmd_data = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    cmd_v = 1'b0;
    rsp_start = start;
    rsp_busy  = busy;
    chk("resp_v", {63'd0, resp_v}, 64'd1);
    chk("resp_hdr", {resp_type, resp_addr, resp_size, resp_payload},
        {t, a, 3'd3, p});
    data = resp_data;
    if (t == uc_wr) chk("wr_resp_data", resp_data, 64'd0);
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
  endtask

  task automatic wr(input logic [39:0] a, input logic [63:0] d);
    logic [63:0] tmp;
    cmd(uc_wr, a, d, a[15:0] ^ 16'h5a5a, tmp);
  endtask

  task automatic rd_chk(input string tag, input logic [39:0] a, input logic [63:0] exp);
    logic [63:0] tmp;
    cmd(uc_rd, a, 64'hffff_ffff_ffff_ffff, a[15:0] ^ 16'hc3c3, tmp);
    chk(tag, tmp, exp);
  endtask

  task automatic pulse_done(input logic [63:0] r);
    done = 1'b1; result = r;
    @(negedge clk);
    done = 1'b0; result = '0;
  endtask

  initial begin
    int s0;
    reset_n = 1'b0; cmd_v = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_size = '0;
    cmd_payload = '0; cmd_data = '0; resp_yumi = 1'b0; done = 1'b0; result = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {cmd_ready, resp_v, start, busy, a_ptr, b_ptr, len},
        {4'b0000, 40'd0, 40'd0, 16'd0});
    reset_n = 1'b1;
    #1 chk("ready_before_edge", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    chk("ready_after_edge", {63'd0, cmd_ready}, 64'd1);

    // Configuration round trip; upper address bits must be ignored.
    wr(40'h00_0000_0000, 64'h8000_1000);
    wr(40'h12_3400_0008, 64'h8000_2000);
    wr(40'h00_0000_0010, 64'hffff_0000_0000_0040);
    chk("a_ptr_o", {24'd0, a_ptr}, 64'h8000_1000);
    chk("b_ptr_o", {24'd0, b_ptr}, 64'h8000_2000);
    chk("len_o", {48'd0, len}, 64'h40);
    rd_chk("rd_a_ptr", 40'h00_0000_0000, 64'h8000_1000);
    rd_chk("rd_b_ptr", 40'hff_0000_0008, 64'h8000_2000);
    rd_chk("rd_len", 40'h00_0000_0010, 64'h40);
    rd_chk("rd_start", 40'h00_0000_0018, 64'h0);
    wr(40'h00_0000_0030, 64'h1234);
    rd_chk("rd_unmapped", 40'h00_0000_0030, 64'h0);

    // done while idle is ignored
    pulse_done(64'h99);
    rd_chk("idle_done_status", 40'h20, 64'h0);
    rd_chk("idle_done_result", 40'h28, 64'h0);

    s0 = start_cnt;
    wr(40'h18, 64'h1);
    chk("start_pulse", {62'd0, rsp_start, rsp_busy}, 64'b11);
    chk("start_one_cycle", {63'd0, start}, 64'd0);
    chk("start_count", 64'(start_cnt - s0), 64'd1);
    rd_chk("status_busy", 40'h20, 64'h1);
    pulse_done(64'h1234);
    chk("busy_cleared", {63'd0, busy}, 64'd0);
    rd_chk("status_done", 40'h20, 64'h2);
    rd_chk("result", 40'h28, 64'h1234);
    rd_chk("status_cleared", 40'h20, 64'h0);

    // Two STARTs back to back: second is an overrun.
    s0 = start_cnt;
    wr(40'h18, 64'h1);
    wr(40'h18, 64'h1);
    chk("overrun_start_count", 64'(start_cnt - s0), 64'd1);
    rd_chk("status_overrun", 40'h20, 64'h5);

    // START coincident with done: done taken, START still an overrun.
    cmd_v = 1'b1; cmd_type = uc_wr; cmd_addr = 40'h18; cmd_data = 64'h1; cmd_payload = 16'h7;
    done = 1'b1; result = 64'h77;
    s0 = start_cnt;
    @(negedge clk);
    cmd_v = 1'b0; done = 1'b0; result = '0;
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
    chk("coinc_start_count", 64'(start_cnt - s0), 64'd0);
    rd_chk("coinc_status", 40'h20, 64'h6);
    rd_chk("coinc_result", 40'h28, 64'h77);

    // Non-uc_rd type reads without clearing sticky STATUS.
    wr(40'h18, 64'h1);
    pulse_done(64'hab);
    begin
      logic [63:0] tmp;
      cmd(4'b0000, 40'h20, 64'h0, 16'h0101, tmp);
      chk("other_type_status", tmp, 64'h2);
    end
    rd_chk("status_after_other", 40'h20, 64'h2);
    rd_chk("status_cleared2", 40'h20, 64'h0);

    // done coincident with a STATUS read.
    wr(40'h18, 64'h1);
    cmd_v = 1'b1; cmd_type = uc_rd; cmd_addr = 40'h20; cmd_payload = 16'h2222;
    done = 1'b1; result = 64'h55;
    @(negedge clk);
    cmd_v = 1'b0; done = 1'b0; result = '0;
    chk("coinc_status_resp", resp_data, 64'h1);
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
    rd_chk("coinc_done_kept", 40'h20, 64'h2);

    // Backpressure: response held, next command not accepted.
    cmd_v = 1'b1; cmd_type = uc_rd; cmd_addr = 40'h10; cmd_payload = 16'hbeef; cmd_data = '0;
    @(negedge clk);
    cmd_type = uc_wr; cmd_addr = 40'h0; cmd_payload = 16'h1111; cmd_data = 64'hdead;
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", {29'd0, resp_v, cmd_ready, resp_type, resp_addr[7:0], resp_payload, resp_data[15:0]},
          {29'd0, 1'b1, 1'b0, uc_rd, 8'h10, 16'hbeef, 16'h40});
      @(negedge clk);
    end
    cmd_v = 1'b0;
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
    chk("stall_release", {62'd0, resp_v, cmd_ready}, 64'b01);
    chk("stall_no_write", {24'd0, a_ptr}, 64'h8000_1000);

    // Async reset while a response is pending and the accelerator is busy.
    wr(40'h18, 64'h1);
    cmd_v = 1'b1; cmd_type = uc_rd; cmd_addr = 40'h28; cmd_payload = 16'h3333;
    @(negedge clk);
    cmd_v = 1'b0;
    chk("pre_reset_state", {62'd0, resp_v, busy}, 64'b11);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_drop", {61'd0, resp_v, busy, cmd_ready}, 64'b000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_resp", {63'd0, resp_v}, 64'd0);
    end
    chk("post_reset_csr", {cmd_ready, busy, a_ptr}, {1'b1, 1'b0, 40'd0});
    rd_chk("post_reset_status", 40'h20, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0x0 exp=0x1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_cacc_csr_endpoint.md
# bp_cacc_csr_endpoint

Memory-mapped control endpoint for a coherent accelerator tile, directly downstream of the tile's I/O CCE. Consumes the CCE's uncached I/O command stream, holds the accelerator's configuration CSRs, launches the datapath via a start pulse, and captures its result. Returns one I/O response per command on a valid/yumi channel, so it connects to the CCE's `io_cmd`/`io_resp` ports with no glue.

## Interface
- `addr_width_p`, default 40: physical address width.
- `data_width_p`, default 64: I/O data width; all CSRs are at most this wide.
- `payload_width_p`, default 16: opaque header payload, echoed unchanged.
- `len_width_p`, default 16: width of the LEN CSR.

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `io_cmd_v_i`, in, 1: command valid.
- `io_cmd_ready_and_o`, out, 1: ready-and handshake.
- `io_cmd_type_i`, in, 4: bedrock mem message type.
- `io_cmd_addr_i`, in, `addr_width_p`: command address.
- `io_cmd_size_i`, in, 3: command size.
- `io_cmd_payload_i`, in, `payload_width_p`: opaque payload.
- `io_cmd_data_i`, in, `data_width_p`: write data.
- `io_resp_v_o`, out, 1: response valid.
- `io_resp_yumi_i`, in, 1: response consumed.
- `io_resp_type_o` / `io_resp_addr_o` / `io_resp_size_o` / `io_resp_payload_o`: out, same widths as the command fields; echoed command header.
- `io_resp_data_o`, out, `data_width_p`: read data; 0 for writes.
- `start_o`, out, 1: one-cycle launch pulse to the datapath.
- `busy_o`, out, 1: accelerator busy.
- `a_ptr_o`, `b_ptr_o`, out, `addr_width_p`: operand pointers.
- `len_o`, out, `len_width_p`: vector length.
- `done_i`, in, 1: one-cycle completion pulse from the datapath.
- `result_i`, in, `data_width_p`: result, valid with `done_i`.

## Operation
- CSR select is `addr[7:3]`; higher address bits are ignored.
  - 0x00 A_PTR: RW.
  - 0x08 B_PTR: RW.
  - 0x10 LEN: RW.
  - 0x18 START: W; reads 0.
  - 0x20 STATUS: R. bit0 = busy, bit1 = done (sticky, cleared by a STATUS read), bit2 = overrun (sticky, cleared by a STATUS read).
  - 0x28 RESULT: R.
- Unmapped offsets read 0; writes to them are dropped.
- Type decode:
  - `e_bedrock_mem_uc_wr` writes.
  - `e_bedrock_mem_uc_rd` reads.
  - Any other type is treated as a read with no side effects, including no STATUS clear.
- Size is ignored. Writes take `io_cmd_data_i` truncated to the CSR width. Reads are zero-extended.
- Command FSM:
  - `e_ready`: `io_cmd_ready_and_o` = 1. On accept, register the response and go to `e_resp`.
  - `e_resp`: `io_cmd_ready_and_o` = 0 and `io_resp_v_o` = 1, with response fields held stable. On `io_resp_yumi_i`, return to `e_ready`.
- Accelerator FSM:
  - `e_idle`: an accepted START write sets busy and raises `start_o` on the next cycle.
  - `e_busy`: `done_i` latches `result_i` into RESULT, sets done, clears busy, and returns to `e_idle`.
  - A START write while in `e_busy` is dropped and sets overrun.
  - `done_i` while in `e_idle` is ignored.
- `a_ptr_o`, `b_ptr_o`, `len_o` drive the CSR values continuously. Software must not change them while busy; the block does not block such writes.

## Timing
- Reset (asynchronous, `reset_n_i` = 0): every output and CSR is 0, both FSMs are idle, and any pending response is discarded. `io_cmd_ready_and_o` rises on the first clock edge after deassertion.
- Accept edge = `io_cmd_v_i & io_cmd_ready_and_o`.
- CSR writes take effect at the accept edge. `io_resp_v_o` is high from the next cycle.
- Minimum command spacing is 2 cycles (accept, then a same-cycle yumi).
- `start_o` is high exactly in the cycle after the START accept edge. `busy_o` is high from that same cycle.
- Read data reflects CSR state before the accept edge.
- `done_i` coincident with a STATUS read: the response shows done = 0, and done is then set. The event is not lost.
- `done_i` coincident with a START accept: done is processed first, but the START is still treated as arriving while busy. It is dropped and sets overrun.
- `io_resp_yumi_i` is only legal while `io_resp_v_o` = 1. Yumi while idle is ignored.

## Test plan
- Reset release: all outputs 0; `io_cmd_ready_and_o` = 1 one cycle after `reset_n_i` rises.
- Write A_PTR=0x8000_1000, B_PTR=0x8000_2000, LEN=0x40, then read each back. Responses return the same values, and header/payload are echoed exactly.
- Write START. `start_o` pulses one cycle and STATUS reads 0x1. Then `done_i` with `result_i`=0x1234: STATUS reads 0x2, RESULT reads 0x1234, and a second STATUS read returns 0x0.
- START written twice back-to-back while busy: exactly one `start_o` pulse, and STATUS reads 0x5.
- Hold `io_resp_yumi_i` low for 10 cycles: response fields stay stable and the next command is not accepted. Yumi releases it.
- Assert `reset_n_i` low while in `e_resp` and busy: `io_resp_v_o` and `busy_o` drop immediately without a clock, and no stale response appears after release.
